// File: rtl/prog_loader_pkg.sv
// Shared configuration for the program loader: byte-lane width, memory
// geometry defaults, FSM state encoding and a small sizing helper.
package prog_loader_pkg;

   localparam int BYTE_W                   = 8;
   localparam int DEFAULT_INSTR_ADDR_WIDTH = 20;
   localparam int DEFAULT_STEP             = 4;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   // Width of the byte-within-word index; never narrower than one bit so
   // a single-byte word still has a legal index register.
   function automatic int idx_width(input int step);
      return (step > 1) ? $clog2(step) : 1;
   endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: packs an upstream byte stream little-endian into
// STEP-byte words and writes them to consecutive program-memory addresses,
// holding the core off (busy) for the whole session.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH = DEFAULT_INSTR_ADDR_WIDTH,
   parameter int STEP             = DEFAULT_STEP
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [INSTR_ADDR_WIDTH-1:0] word_count,
   input  logic                        abort,
   input  logic                        byte_valid,
   input  logic [BYTE_W-1:0]           byte_data,
   output logic                        byte_ready,
   output logic                        pgm,
   output logic [INSTR_ADDR_WIDTH-1:0] addr,
   output logic [STEP*BYTE_W-1:0]      data,
   output logic                        busy,
   output logic                        done
);

   localparam int                          IDX_W    = idx_width(STEP);
   localparam logic [IDX_W-1:0]            LAST_IDX = IDX_W'(STEP - 1);
   localparam logic [IDX_W-1:0]            IDX_ONE  = IDX_W'(1);
   localparam logic [INSTR_ADDR_WIDTH-1:0] ADDR_ONE = INSTR_ADDR_WIDTH'(1);

   state_t                        state;
   state_t                        state_next;
   logic [INSTR_ADDR_WIDTH-1:0]   count_q;
   logic [INSTR_ADDR_WIDTH-1:0]   addr_q;
   logic [STEP*BYTE_W-1:0]        data_q;
   logic [IDX_W-1:0]              idx_q;
   logic                          accept;
   logic                          last_byte;
   logic                          last_word;

   // A byte moves only on a valid/ready handshake; byte_ready already
   // drops under abort, so abort automatically wins over acceptance.
   assign accept    = byte_valid && byte_ready;
   assign last_byte = (idx_q == LAST_IDX);
   // Only evaluated in WRITE, where the latched count is known to be nonzero.
   assign last_word = (addr_q == (count_q - ADDR_ONE));

   assign addr = addr_q;
   assign data = data_q;

   // State register: reset drops straight back to IDLE from any state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: start only counts in IDLE, abort cancels everywhere
   // except that an in-flight write still lands before returning to IDLE.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_next = (word_count == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (accept && last_byte) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            if (abort) begin
               state_next = S_IDLE;
            end else if (last_word) begin
               state_next = S_DONE;
            end else begin
               state_next = S_COLLECT;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: strobes are pure functions of state, with abort
   // masking byte_ready and the completion pulse.
   always_comb begin
      byte_ready = (state == S_COLLECT) && !abort;
      pgm        = (state == S_WRITE);
      busy       = (state != S_IDLE);
      done       = (state == S_DONE) && !abort;
   end

   // Session datapath: latch the count, pack bytes into their lanes and
   // step the write address between words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         idx_q   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  count_q <= word_count;
                  addr_q  <= '0;
                  idx_q   <= '0;
               end
            end
            S_COLLECT: begin
               if (abort) begin
                  idx_q <= '0;
               end else if (accept) begin
                  for (int k = 0; k < STEP; k++) begin
                     if (idx_q == IDX_W'(k)) begin
                        data_q[k*BYTE_W +: BYTE_W] <= byte_data;
                     end
                  end
                  idx_q <= last_byte ? '0 : (idx_q + IDX_ONE);
               end
            end
            S_WRITE: begin
               if (!abort && !last_word) begin
                  addr_q <= addr_q + ADDR_ONE;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
